// File: rtl/determinante_seq.sv
// determinante_seq
//   Sequential determinant unit for signed 2x2 and 3x3 matrices. One signed
//   multiplier is reused across all steps: 2 steps for 2x2, 9 steps for 3x3
//   (cofactor expansion along the first row, each 2x2 minor built in a
//   dedicated minor register). The exact result is exported on det_full. A
//   narrowed copy is exported on det, either truncated or saturated.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high; clears state, datapath and outputs
//   start         in   job request, sampled only while idle
//   mode          in   0 = 2x2, 1 = 3x3 (captured with start)
//   matriz        in   9 elements, row-major, a11 in the most significant slot
//   busy          out  high while steps are being executed
//   done          out  one-cycle pulse when det/det_full/overflow_flag update
//   det           out  narrowed signed determinant (DATA_W bits)
//   det_full      out  exact signed determinant (ACC_W bits)
//   overflow_flag out  det_full does not fit in signed DATA_W
module determinante_seq #(
  parameter int DATA_W   = 8,
  parameter bit SATURATE = 1'b0,
  localparam int ACC_W   = 3*DATA_W+3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [9*DATA_W-1:0]      matriz,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] det,
  output logic signed [ACC_W-1:0]  det_full,
  output logic                     overflow_flag
);

  localparam int MIN_W  = 2*DATA_W+1;
  localparam int PROD_W = DATA_W + MIN_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [ACC_W-1:0] DET_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] DET_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]               state;
  logic [3:0]               cnt;
  logic                     mode_q;
  logic [9*DATA_W-1:0]      mat_q;
  logic signed [MIN_W-1:0]  minor_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [DATA_W-1:0] e [9];

  // Per-step control decoded from (mode, step)
  logic signed [DATA_W-1:0] op_a;
  logic signed [MIN_W-1:0]  op_b;
  logic                     wr_acc;
  logic                     ld;
  logic                     sub;
  logic                     last;

  logic signed [PROD_W-1:0] prod;
  logic signed [MIN_W-1:0]  prod_m;
  logic signed [ACC_W-1:0]  prod_acc;
  logic signed [MIN_W-1:0]  minor_nxt;
  logic signed [ACC_W-1:0]  acc_nxt;

  function automatic logic is_ovf(input logic signed [ACC_W-1:0] v);
    return (v > DET_MAX) || (v < DET_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    r = v[DATA_W-1:0];
    if (SATURATE) begin
      if (v > DET_MAX)      r = {1'b0, {(DATA_W-1){1'b1}}};
      else if (v < DET_MIN) r = {1'b1, {(DATA_W-1){1'b0}}};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      e[i] = mat_q[(8-i)*DATA_W +: DATA_W];
    end
  end

  // Step schedule. Element-by-element products go to the minor register
  // (load then subtract); element-by-minor products go to the accumulator
  // with the cofactor sign (+, -, +). The 2x2 case writes acc directly.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    wr_acc = 1'b0;
    ld     = 1'b0;
    sub    = 1'b0;
    last   = 1'b0;
    if (!mode_q) begin
      case (cnt)
        4'd0: begin op_a = e[0]; op_b = MIN_W'(e[3]); wr_acc = 1'b1; ld = 1'b1; end
        4'd1: begin op_a = e[1]; op_b = MIN_W'(e[2]); wr_acc = 1'b1; sub = 1'b1; last = 1'b1; end
        default: ;
      endcase
    end else begin
      case (cnt)
        4'd0: begin op_a = e[4]; op_b = MIN_W'(e[8]); ld = 1'b1; end
        4'd1: begin op_a = e[5]; op_b = MIN_W'(e[7]); sub = 1'b1; end
        4'd2: begin op_a = e[0]; op_b = minor_q; wr_acc = 1'b1; end
        4'd3: begin op_a = e[3]; op_b = MIN_W'(e[8]); ld = 1'b1; end
        4'd4: begin op_a = e[5]; op_b = MIN_W'(e[6]); sub = 1'b1; end
        4'd5: begin op_a = e[1]; op_b = minor_q; wr_acc = 1'b1; sub = 1'b1; end
        4'd6: begin op_a = e[3]; op_b = MIN_W'(e[7]); ld = 1'b1; end
        4'd7: begin op_a = e[4]; op_b = MIN_W'(e[6]); sub = 1'b1; end
        4'd8: begin op_a = e[2]; op_b = minor_q; wr_acc = 1'b1; last = 1'b1; end
        default: ;
      endcase
    end
  end

  // Single shared multiplier; operands are sign-extended to the full product
  // width so no input combination can wrap.
  always_comb begin
    prod      = PROD_W'(op_a) * PROD_W'(op_b);
    // Element-by-element products always fit in the minor width.
    prod_m    = prod[MIN_W-1:0];
    prod_acc  = ACC_W'(prod);
    minor_nxt = ld ? prod_m : (sub ? minor_q - prod_m : minor_q + prod_m);
    acc_nxt   = ld ? prod_acc : (sub ? acc_q - prod_acc : acc_q + prod_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      mode_q        <= 1'b0;
      mat_q         <= '0;
      minor_q       <= '0;
      acc_q         <= '0;
      det           <= '0;
      det_full      <= '0;
      overflow_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mat_q   <= matriz;
            mode_q  <= mode;
            cnt     <= '0;
            minor_q <= '0;
            acc_q   <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt + 4'd1;
          if (wr_acc) acc_q   <= acc_nxt;
          else        minor_q <= minor_nxt;
          if (last) begin
            det_full      <= acc_nxt;
            det           <= narrow(acc_nxt);
            overflow_flag <= is_ovf(acc_nxt);
            state         <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_determinante_seq.sv
// Testbench for determinante_seq: two instances (truncating and saturating)
// share the same stimulus. Expected results come from a plain-integer
// determinant model and are queued when a job is accepted; a monitor pops
// and compares whenever done is seen.
module tb_determinante_seq;

  localparam int DW = 8;
  localparam int AW = 3*DW+3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [9*DW-1:0]   matriz;
  logic              busy0, busy1, done0, done1, ovf0, ovf1;
  logic signed [DW-1:0] det0, det1;
  logic signed [AW-1:0] full0, full1;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    longint          full;
    longint          ovf;
    longint          dtr;
    longint          dsat;
    int              cyc;
  } exp_t;

  exp_t sbq[$];

  determinante_seq #(.DATA_W(DW), .SATURATE(1'b0)) dut_trunc (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .matriz(matriz),
    .busy(busy0), .done(done0), .det(det0), .det_full(full0), .overflow_flag(ovf0)
  );

  determinante_seq #(.DATA_W(DW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .matriz(matriz),
    .busy(busy1), .done(done1), .det(det1), .det_full(full1), .overflow_flag(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Determinant by the rule of Sarrus / direct 2x2 formula.
  function automatic longint ref_det(input bit m, input int el[9]);
    longint a[9];
    for (int i = 0; i < 9; i++) a[i] = el[i];
    if (!m) return a[0]*a[3] - a[1]*a[2];
    return a[0]*a[4]*a[8] + a[1]*a[5]*a[6] + a[2]*a[3]*a[7]
         - a[2]*a[4]*a[6] - a[1]*a[3]*a[8] - a[0]*a[5]*a[7];
  endfunction

  function automatic exp_t make_exp(input bit m, input int el[9]);
    exp_t   x;
    longint d;
    logic signed [DW-1:0] lo;
    d      = ref_det(m, el);
    lo     = DW'(d);
    x.full = d;
    x.ovf  = (d > 127 || d < -128) ? 1 : 0;
    x.dtr  = lo;
    x.dsat = (d > 127) ? 127 : ((d < -128) ? -128 : d);
    x.cyc  = 0;
    return x;
  endfunction

  function automatic logic [9*DW-1:0] pack(input int el[9]);
    logic [9*DW-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[(8-i)*DW +: DW] = DW'(el[i]);
    return v;
  endfunction

  // Issue one job; optionally scramble start/mode/matriz on every cycle the
  // unit is busy or finishing. Returns one cycle after the unit is idle again.
  task automatic run_job(input bit m, input int el[9], input bit toggle);
    exp_t x;
    int   lat;
    logic [95:0] rnd;
    lat    = m ? 9 : 2;
    mode   = m;
    matriz = pack(el);
    start  = 1'b1;
    @(posedge clk); #1;
    x     = make_exp(m, el);
    x.cyc = cyc + lat;
    sbq.push_back(x);
    chk("busy_after_start", busy0, 1);
    for (int k = 0; k <= lat; k++) begin
      if (toggle) begin
        rnd    = {$urandom(), $urandom(), $urandom()};
        start  = rnd[0];
        mode   = rnd[1];
        matriz = rnd[9*DW-1:0];
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t x;
    if (done0 === 1'b1 || done1 === 1'b1) begin
      if (sbq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_done: got done0=%0d done1=%0d expected no done (cycle %0d)",
                 done0, done1, cyc);
      end else begin
        x = sbq.pop_front();
        chk("done_cycle",      cyc, x.cyc);
        chk("done_both",       {done0, done1}, 2'b11);
        chk("busy_during_done", busy0, 0);
        chk("det_full",        full0, x.full);
        chk("det_full_sat",    full1, x.full);
        chk("overflow",        ovf0, x.ovf);
        chk("overflow_sat",    ovf1, x.ovf);
        chk("det_trunc",       det0, x.dtr);
        chk("det_sat",         det1, x.dsat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int el[9];
    bit seen;
    reset  = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    matriz = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  busy0, 0);
    chk("rst_done",  done0, 0);
    chk("rst_det",   det0, 0);
    chk("rst_full",  full0, 0);
    chk("rst_ovf",   ovf0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_det1",  det1, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 2x2 [1 2;3 4], unused slots filled with garbage
    el = '{1, 2, 3, 4, 99, -77, 5, 120, -3};
    run_job(1'b0, el, 1'b0);
    // 2x2 overflow case
    el = '{127, -128, 127, 127, 0, 0, 0, 0, 0};
    run_job(1'b0, el, 1'b0);
    // 3x3 small matrix with narrow overflow
    el = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
    run_job(1'b1, el, 1'b0);
    // 3x3 all -128
    el = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    run_job(1'b1, el, 1'b0);
    // 3x3 large intermediate products
    el = '{-128, 127, 0, 0, -128, 127, 127, 0, -128};
    run_job(1'b1, el, 1'b0);
    // Scrambled inputs during CALC/DONE
    el = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
    run_job(1'b1, el, 1'b1);
    el = '{127, -128, 127, 127, 1, 2, 3, 4, 5};
    run_job(1'b0, el, 1'b1);

    // Reset in the middle of a 3x3 job: previous outputs are nonzero
    el = '{3, -7, 11, 2, 9, -4, 8, 1, 6};
    mode   = 1'b1;
    matriz = pack(el);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy0, 0);
    chk("midrst_done", done0, 0);
    chk("midrst_det",  det0, 0);
    chk("midrst_full", full0, 0);
    chk("midrst_ovf",  ovf0, 0);
    chk("midrst_det1", det1, 0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);

    // start and reset together: block stays idle
    @(posedge clk); #1;
    start  = 1'b1;
    reset  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    chk("start_rst_idle", busy0, 0);
    repeat (3) @(negedge clk);
    chk("start_rst_no_busy", busy0, 0);
    @(posedge clk); #1;

    // Normal job after reset
    el = '{3, -7, 11, 2, 9, -4, 8, 1, 6};
    run_job(1'b1, el, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 9; i++) begin
        case ($urandom_range(0, 5))
          0:       el[i] = -128;
          1:       el[i] = 127;
          default: el[i] = int'($urandom_range(0, 255)) - 128;
        endcase
      end
      run_job(1'($urandom_range(0, 1)), el, (j % 3) == 0);
    end

    for (int t = 0; t < 30 && sbq.size() != 0; t++) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/determinante_seq.md
# determinante_seq

Sequential, parametrised determinant unit for signed 2x2 and 3x3 matrices with a start/done handshake. It replaces the fixed 8-bit combinational 2x2 block in the matrix-operations datapath. It generalises element width, adds a 3x3 mode computed by cofactor expansion over one shared signed multiplier, and adds selectable truncate/saturate output. A full-precision result is exported alongside the narrowed one.

## Interface
- DATA_W, 8, element width (signed two's complement), ≥ 2
- SATURATE, 0, 0 = narrowed output is low DATA_W bits of full result (legacy behaviour); 1 = clamp to signed DATA_W range
- localparam ACC_W = 3*DATA_W+3, full-result width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = 2x2, 1 = 3x3; captured with start
- matriz  in  9*DATA_W  row-major, element e0 (a11) in the most significant slot, e8 (a33) in the least significant slot
  - 2x2 mode uses e0..e3 as a11, a12, a21, a22 in the top 4*DATA_W bits; the rest is ignored
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when results update
- det  out  DATA_W  signed narrowed determinant
- det_full  out  ACC_W  signed exact determinant
- overflow_flag  out  1  det_full outside [-2^(DATA_W-1), 2^(DATA_W-1)-1]

## Operation
- States: IDLE, CALC, DONE.
  - IDLE→CALC on start=1. On that edge, matriz and mode are registered, the step counter is cleared, and the accumulators are cleared.
  - CALC→DONE on the edge that executes the final step.
  - DONE→IDLE unconditionally on the next edge.
- start is ignored in CALC and DONE. Input changes after capture have no effect.
- Each CALC edge performs exactly one signed multiply with add/subtract. There is one multiplier instance only.
- 2x2 sequence, 2 steps: acc = a11*a22, then acc -= a12*a21.
- 3x3 sequence, 9 steps: three minor groups of 3 steps each.
  - Group 1: m = e4*e8; m -= e5*e7; acc += e0*m.
  - Group 2: m = e3*e8; m -= e5*e6; acc -= e1*m.
  - Group 3: m = e3*e7; m -= e4*e6; acc += e2*m.
- Width rules:
  - The minor register holds 2*DATA_W+1 bits.
  - acc holds ACC_W bits.
  - All operands are sign-extended before multiply and add. No intermediate wrap is permitted for any input values.
- On the CALC→DONE edge, these are registered:
  - det_full = acc (sign-extended in 2x2 mode).
  - overflow_flag.
  - det = acc[DATA_W-1:0] if SATURATE=0. Otherwise det = +max on positive overflow and −min on negative overflow.
- det, det_full and overflow_flag hold until the next completion or reset.
- Reset, including mid-CALC: state to IDLE, counters and accumulators to 0, and all outputs to 0. No done pulse is produced for the aborted job.
- start and reset high together: reset wins.

## Timing
- Reset values: busy=0, done=0, det=0, det_full=0, overflow_flag=0.
- Let edge E0 be the edge where start is accepted in IDLE.
  - busy=1 from after E0 until the final-step edge.
  - The final step is at E2 (2x2) or E9 (3x3).
  - Results and done=1 are visible after E2 or E9.
  - done lasts exactly one cycle. busy=0 whenever done=1.
- Latency, start edge to done visible: 2 cycles (2x2) or 9 cycles (3x3).
- Earliest next acceptance is the edge after done deasserts. Throughput is one job per 4 cycles (2x2) or 11 cycles (3x3).

## Test plan
- DATA_W=8, 2x2 [1 2;3 4]: det=-2, det_full=-2, overflow_flag=0; done exactly 2 cycles after the start edge.
- 2x2 [127 -128;127 127]: det_full=32385, overflow_flag=1. det=-127 (0x81) with SATURATE=0; det=127 with SATURATE=1.
- 3x3 [6 1 1;4 -2 5;2 8 7]: det_full=-306, overflow_flag=1, done 9 cycles after start. det=-50 (0xCE) with SATURATE=0; det=-128 with SATURATE=1.
- 3x3 all elements -128: det_full=0, overflow_flag=0.
  - 3x3 [-128 127 0;0 -128 127;127 0 -128]: det_full=-2097152+2048383=-48769, with no intermediate wrap.
- Toggle start and matriz every cycle during CALC: only the first request completes, and results match the captured matrix.
- Assert reset at step 5 of a 3x3 job: all outputs 0 on the next cycle, no done pulse, and a new start afterwards completes normally. start and reset high in the same cycle leaves the block in IDLE.
